opb_slave_bridge: RTL and testbench

//  Parametrised OPB slave interface; successor to the fixed 32/16-bit slave FSM.

---
 rtl/opb_slave_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_opb_slave_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_slave_bridge.sv
// ------------------------------------------------------------------------
// opb_slave_bridge: OPB slave with masked window decode, posted-write FIFO
// and backend read handshake with timeout.   Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module opb_slave_bridge #(
  parameter int unsigned   DW         = 32,
  parameter int unsigned   AW         = 16,
  parameter logic [AW-1:0] BASE_ADDR  = 16'h0000,
  parameter logic [AW-1:0] ADDR_MASK  = 16'hFF00,
  parameter int unsigned   FIFO_DEPTH = 4,
  parameter int unsigned   RD_TIMEOUT = 15
) (
  input  logic          opb_clk,
  input  logic          reset,
  input  logic          opb_select,
  input  logic          opb_rnw,
  input  logic [AW-1:0] opb_abus,
  input  logic [DW-1:0] opb_dbus,
  output logic [DW-1:0] sl_dbus,
  output logic          sl_xferack,
  output logic          sl_errack,
  output logic          sl_toutsup,
  output logic          wr_en,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_valid,
  input  logic [DW-1:0] rd_data
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_STALL = 3'd1,
    S_RD_DRAIN = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          xferack_q, xferack_d;
  logic          errack_q, errack_d;
  logic          toutsup_q, toutsup_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] sl_dbus_q, sl_dbus_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [AW-1:0] addr_mem_q [FIFO_DEPTH];
  logic [DW-1:0] data_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic push, pop, full, empty, hit;

  assign hit   = (opb_abus & ADDR_MASK) == BASE_ADDR;
  // Depth is a power of two, so the count MSB is set only when full.
  assign full  = count_q[PW];
  assign empty = (count_q == '0);
  assign pop   = !empty && wr_ready;

  always_comb begin
    state_d   = state_q;
    xferack_d = 1'b0;
    errack_d  = 1'b0;
    sl_dbus_d = '0;
    toutsup_d = toutsup_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (opb_select && hit) begin
          if (!opb_rnw) begin
            if (!full) begin
              push      = 1'b1;
              xferack_d = 1'b1;
              state_d   = S_DONE;
            end else begin
              toutsup_d = 1'b1;
              state_d   = S_WR_STALL;
            end
          end else if (empty) begin
            rd_en_d   = 1'b1;
            rd_addr_d = opb_abus;
            cnt_d     = '0;
            state_d   = S_RD_WAIT;
          end else begin
            // Posted writes must reach the backend before the read is issued.
            toutsup_d = 1'b1;
            state_d   = S_RD_DRAIN;
          end
        end
      end
      S_WR_STALL: begin
        if (!opb_select) begin
          toutsup_d = 1'b0;
          state_d   = S_IDLE;
        end else if (!full) begin
          push      = 1'b1;
          xferack_d = 1'b1;
          toutsup_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_RD_DRAIN: begin
        if (!opb_select) begin
          toutsup_d = 1'b0;
          state_d   = S_IDLE;
        end else if (empty) begin
          rd_en_d   = 1'b1;
          rd_addr_d = opb_abus;
          cnt_d     = '0;
          toutsup_d = 1'b0;
          state_d   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (!opb_select) begin
          toutsup_d = 1'b0;
          state_d   = S_IDLE;
        end else if (rd_valid) begin
          sl_dbus_d = rd_data;
          xferack_d = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q == 8'(RD_TIMEOUT)) begin
          errack_d  = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d     = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge opb_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      xferack_q <= 1'b0;
      errack_q  <= 1'b0;
      toutsup_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      sl_dbus_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      xferack_q <= xferack_d;
      errack_q  <= errack_d;
      toutsup_q <= toutsup_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      sl_dbus_q <= sl_dbus_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge opb_clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_mem_q[wptr_q] <= opb_abus;
        data_mem_q[wptr_q] <= opb_dbus;
        wptr_q             <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign sl_dbus    = sl_dbus_q;
  assign sl_xferack = xferack_q;
  assign sl_errack  = errack_q;
  assign sl_toutsup = toutsup_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign wr_en      = !empty;
  assign wr_addr    = addr_mem_q[rptr_q];
  assign wr_data    = data_mem_q[rptr_q];

endmodule

`default_nettype wire

// File: tb/tb_opb_slave_bridge.sv
// ------------------------------------------------------------------------
// tb_opb_slave_bridge: directed self-checking bench for opb_slave_bridge.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_opb_slave_bridge;

  logic        opb_clk;
  logic        reset;
  logic        opb_select;
  logic        opb_rnw;
  logic [15:0] opb_abus;
  logic [31:0] opb_dbus;
  logic [31:0] sl_dbus;
  logic        sl_xferack;
  logic        sl_errack;
  logic        sl_toutsup;
  logic        wr_en;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  opb_slave_bridge #(
    .DW(32), .AW(16), .BASE_ADDR(16'h1200), .ADDR_MASK(16'hFF00),
    .FIFO_DEPTH(4), .RD_TIMEOUT(15)
  ) dut (
    .opb_clk(opb_clk), .reset(reset), .opb_select(opb_select), .opb_rnw(opb_rnw),
    .opb_abus(opb_abus), .opb_dbus(opb_dbus), .sl_dbus(sl_dbus),
    .sl_xferack(sl_xferack), .sl_errack(sl_errack), .sl_toutsup(sl_toutsup),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  initial opb_clk = 1'b0;
  always #5 opb_clk = ~opb_clk;

  task automatic tick();
    @(posedge opb_clk);
    #1;
  endtask

  // Bus driver only: performs a write, waits bounded for xferack, then idles one cycle.
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, output logic ok);
    opb_select = 1'b1; opb_rnw = 1'b0; opb_abus = a; opb_dbus = d; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (sl_xferack) ok = 1'b1;
    end
    opb_select = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; opb_select = 1'b0; opb_rnw = 1'b0; opb_abus = '0; opb_dbus = '0;
    wr_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    tick(); tick();
    n_cmp++;
    if ({sl_dbus, sl_xferack, sl_errack, sl_toutsup, wr_en, rd_en, rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dbus=%h ack=%b err=%b tout=%b wr_en=%b rd_en=%b rd_addr=%h, want all 0",
               sl_dbus, sl_xferack, sl_errack, sl_toutsup, wr_en, rd_en, rd_addr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    wr_ready = 1'b1;
    opb_select = 1'b1; opb_rnw = 1'b0; opb_abus = 16'h1204; opb_dbus = 32'h1234;
    tick();
    n_cmp++;
    if ({sl_xferack, sl_errack, wr_en} !== 3'b101 || wr_addr !== 16'h1204 || wr_data !== 32'h1234) begin
      n_fail++;
      $display("FAIL write_ack: got ack=%b err=%b wr_en=%b addr=%h data=%h, want 1 0 1 1204 00001234",
               sl_xferack, sl_errack, wr_en, wr_addr, wr_data);
    end
    opb_select = 1'b0;
    tick();
    n_cmp++;
    if ({sl_xferack, wr_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL write_done: got ack=%b wr_en=%b, want 0 0", sl_xferack, wr_en);
    end
  endtask

  task automatic test_fifo_full();
    logic ok;
    int   acks = 0;
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_write(16'h1200 + 16'(i), 32'h11 * i, ok);
      if (ok) acks++;
    end
    n_cmp++;
    if (acks !== 4) begin
      n_fail++;
      $display("FAIL fill_acks: got %0d acks, want 4", acks);
    end
    opb_select = 1'b1; opb_rnw = 1'b0; opb_abus = 16'h1204; opb_dbus = 32'h44;
    tick(); tick();
    n_cmp++;
    if ({sl_toutsup, sl_xferack} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_stall: got tout=%b ack=%b, want 1 0", sl_toutsup, sl_xferack);
    end
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    n_cmp++;
    if ({sl_toutsup, sl_xferack} !== 2'b10) begin
      n_fail++;
      $display("FAIL stall_pop_edge: got tout=%b ack=%b, want 1 0", sl_toutsup, sl_xferack);
    end
    tick();
    n_cmp++;
    if ({sl_toutsup, sl_xferack} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_release: got tout=%b ack=%b, want 0 1", sl_toutsup, sl_xferack);
    end
    opb_select = 1'b0;
    tick();
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 16'h1201 || wr_data !== 32'h11) begin
      n_fail++;
      $display("FAIL fifo_head: got wr_en=%b addr=%h data=%h, want 1 1201 00000011", wr_en, wr_addr, wr_data);
    end
    wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 16'h1204 || wr_data !== 32'h44) begin
      n_fail++;
      $display("FAIL fifo_last: got wr_en=%b addr=%h data=%h, want 1 1204 00000044", wr_en, wr_addr, wr_data);
    end
    tick();
    wr_ready = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_drained: got wr_en=%b, want 0", wr_en);
    end
  endtask

  task automatic test_read_drain();
    logic ok;
    wr_ready = 1'b0;
    bus_write(16'h1210, 32'hA0, ok);
    bus_write(16'h1211, 32'hA1, ok);
    opb_select = 1'b1; opb_rnw = 1'b1; opb_abus = 16'h1208;
    tick();
    n_cmp++;
    if ({sl_toutsup, rd_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL drain_enter: got tout=%b rd_en=%b, want 1 0", sl_toutsup, rd_en);
    end
    wr_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_order: got rd_en=%b wr_en=%b, want 0 0", rd_en, wr_en);
    end
    tick();
    n_cmp++;
    if ({rd_en, sl_toutsup} !== 2'b10 || rd_addr !== 16'h1208) begin
      n_fail++;
      $display("FAIL drain_issue: got rd_en=%b tout=%b rd_addr=%h, want 1 0 1208", rd_en, sl_toutsup, rd_addr);
    end
    tick(); tick(); tick();
    n_cmp++;
    if ({rd_en, sl_xferack} !== 2'b00) begin
      n_fail++;
      $display("FAIL read_wait: got rd_en=%b ack=%b, want 0 0", rd_en, sl_xferack);
    end
    rd_valid = 1'b1; rd_data = 32'hCAFE;
    tick();
    rd_valid = 1'b0;
    n_cmp++;
    if (sl_xferack !== 1'b1 || sl_dbus !== 32'hCAFE || sl_errack !== 1'b0) begin
      n_fail++;
      $display("FAIL read_data: got ack=%b err=%b dbus=%h, want 1 0 0000cafe", sl_xferack, sl_errack, sl_dbus);
    end
    opb_select = 1'b0;
    tick();
    n_cmp++;
    if (sl_xferack !== 1'b0 || sl_dbus !== 32'h0) begin
      n_fail++;
      $display("FAIL read_clear: got ack=%b dbus=%h, want 0 00000000", sl_xferack, sl_dbus);
    end
  endtask

  task automatic test_timeout();
    int  cyc = 0;
    logic seen = 1'b0;
    logic any_ack = 1'b0;
    wr_ready = 1'b1;
    opb_select = 1'b1; opb_rnw = 1'b1; opb_abus = 16'h120C;
    tick();
    n_cmp++;
    if (rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL to_rd_en: got rd_en=%b, want 1", rd_en);
    end
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (sl_xferack) any_ack = 1'b1;
      if (sl_errack) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || cyc !== 16 || any_ack !== 1'b0 || sl_dbus !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_errack: got seen=%b after %0d cycles ack=%b dbus=%h, want 1 after 16 0 00000000",
               seen, cyc, any_ack, sl_dbus);
    end
    opb_select = 1'b0;
    tick();
    n_cmp++;
    if (sl_errack !== 1'b0) begin
      n_fail++;
      $display("FAIL errack_pulse: got errack=%b, want 0", sl_errack);
    end
  endtask

  task automatic test_abort();
    opb_select = 1'b1; opb_rnw = 1'b1; opb_abus = 16'h1230;
    tick(); tick();
    opb_select = 1'b0;
    tick();
    rd_valid = 1'b1; rd_data = 32'hBEEF;
    tick();
    rd_valid = 1'b0;
    n_cmp++;
    if ({sl_xferack, sl_errack, sl_toutsup} !== 3'b000 || sl_dbus !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_late_valid: got ack=%b err=%b tout=%b dbus=%h, want 0 0 0 0",
               sl_xferack, sl_errack, sl_toutsup, sl_dbus);
    end
    tick();
  endtask

  task automatic test_miss();
    logic any = 1'b0;
    wr_ready = 1'b0;
    opb_select = 1'b1; opb_rnw = 1'b0; opb_abus = 16'h3404; opb_dbus = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sl_xferack || sl_errack || sl_toutsup || wr_en || rd_en) any = 1'b1;
    end
    opb_rnw = 1'b1; opb_abus = 16'h1300;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sl_xferack || sl_errack || sl_toutsup || wr_en || rd_en) any = 1'b1;
    end
    opb_select = 1'b0;
    n_cmp++;
    if (any !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_miss: got activity=%b, want 0", any);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic ok;
    wr_ready = 1'b0;
    bus_write(16'h1240, 32'hA, ok);
    wr_ready = 1'b1;
    opb_select = 1'b1; opb_rnw = 1'b0; opb_abus = 16'h1241; opb_dbus = 32'hB;
    tick();
    wr_ready = 1'b0;
    n_cmp++;
    if ({sl_xferack, wr_en} !== 2'b11 || wr_addr !== 16'h1241 || wr_data !== 32'hB) begin
      n_fail++;
      $display("FAIL push_pop_same_edge: got ack=%b wr_en=%b addr=%h data=%h, want 1 1 1241 0000000b",
               sl_xferack, wr_en, wr_addr, wr_data);
    end
    opb_select = 1'b0;
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL push_pop_count: got wr_en=%b, want 0", wr_en);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    wr_ready = 1'b1;
    opb_select = 1'b1; opb_rnw = 1'b1; opb_abus = 16'h1220;
    tick(); tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({sl_xferack, sl_errack, sl_toutsup, rd_en} !== 4'b0000 || rd_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_rd_wait: got ack=%b err=%b tout=%b rd_en=%b rd_addr=%h, want 0 0 0 0 0000",
               sl_xferack, sl_errack, sl_toutsup, rd_en, rd_addr);
    end
    opb_select = 1'b0;
    tick();
    reset = 1'b0;
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(16'h1250 + 16'(i), 32'h100 + i, ok);
    opb_select = 1'b1; opb_rnw = 1'b0; opb_abus = 16'h1254; opb_dbus = 32'h104;
    tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({wr_en, sl_toutsup, sl_xferack} !== 3'b000 || wr_addr !== 16'h0 || wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_full: got wr_en=%b tout=%b ack=%b addr=%h data=%h, want 0 0 0 0000 00000000",
               wr_en, sl_toutsup, sl_xferack, wr_addr, wr_data);
    end
    opb_select = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    opb_select = 1'b1; opb_rnw = 1'b0; opb_abus = 16'h1260; opb_dbus = 32'h77;
    tick();
    n_cmp++;
    if (sl_xferack !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 16'h1260) begin
      n_fail++;
      $display("FAIL post_reset_write: got ack=%b wr_en=%b addr=%h, want 1 1 1260", sl_xferack, wr_en, wr_addr);
    end
    opb_select = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fifo_full();
    test_read_drain();
    test_timeout();
    test_abort();
    test_miss();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
